// File: rtl/e_mdu_if.sv
// e_mdu_if: operand/opcode/result bundle between the E stage and the MDU.
// master drives Src_A, Src_B, MDUOp, Start; slave returns Busy, HI, LO, MDUOut.
interface e_mdu_if;
   logic [31:0] Src_A;
   logic [31:0] Src_B;
   logic [3:0]  MDUOp;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUOut;

   modport master (
      output Src_A, Src_B, MDUOp, Start,
      input  Busy, HI, LO, MDUOut
   );

   modport slave (
      input  Src_A, Src_B, MDUOp, Start,
      output Busy, HI, LO, MDUOut
   );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: fixed-latency multiply/divide unit owning HI/LO (E stage).
// Ports: clk, reset (async, active-high), bus (e_mdu_if.slave).
// Optional: define MDU_MADD_EN to accept madd/maddu/msub/msubu.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic   clk,
   input logic   reset,
   e_mdu_if.slave bus
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic          dz_q;
   logic [31:0]   hi_q, lo_q;
   logic [63:0]   tmp_q;

   logic [31:0] a, b;
   assign a = bus.Src_A;
   assign b = bus.Src_B;

   // Both products from 64-bit extended operands; low 64 bits are exact.
   logic [63:0] prod_s, prod_u;
   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'b0, a} * {32'b0, b};

   // Signed divide via magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
   logic [31:0] b_safe, abs_a, abs_b, q_mag, r_mag, squot, srem, uquot, urem;
   assign b_safe = (b == 32'd0) ? 32'd1 : b;
   assign abs_a  = a[31] ? -a : a;
   assign abs_b  = b_safe[31] ? -b_safe : b_safe;
   assign q_mag  = abs_a / abs_b;
   assign r_mag  = abs_a % abs_b;
   assign squot  = (a[31] ^ b_safe[31]) ? -q_mag : q_mag;
   assign srem   = a[31] ? -r_mag : r_mag;
   assign uquot  = a / b_safe;
   assign urem   = a % b_safe;

   logic        go, is_div, mthi_w, mtlo_w;
   logic [63:0] tmp_d;

   always_comb begin
      go     = 1'b0;
      is_div = 1'b0;
      mthi_w = 1'b0;
      mtlo_w = 1'b0;
      tmp_d  = 64'd0;
      case (bus.MDUOp)
         4'b0001: begin go = 1'b1; tmp_d = prod_s; end
         4'b0010: begin go = 1'b1; tmp_d = prod_u; end
         4'b0011: begin go = 1'b1; is_div = 1'b1; tmp_d = {srem, squot}; end
         4'b0100: begin go = 1'b1; is_div = 1'b1; tmp_d = {urem, uquot}; end
         4'b0111: mthi_w = 1'b1;
         4'b1000: mtlo_w = 1'b1;
`ifdef MDU_MADD_EN
         4'b1001: begin go = 1'b1; tmp_d = {hi_q, lo_q} + prod_s; end
         4'b1010: begin go = 1'b1; tmp_d = {hi_q, lo_q} + prod_u; end
         4'b1011: begin go = 1'b1; tmp_d = {hi_q, lo_q} - prod_s; end
         4'b1100: begin go = 1'b1; tmp_d = {hi_q, lo_q} - prod_u; end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         tmp_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.Start) begin
                  if (go) begin
                     tmp_q   <= tmp_d;
                     dz_q    <= is_div && (b == 32'd0);
                     cnt_q   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end else if (mthi_w) begin
                     hi_q <= a;
                  end else if (mtlo_w) begin
                     lo_q <= a;
                  end
               end
            end
            RUN: begin
               if (cnt_q == CW'(1)) begin
                  // Divide by zero burns the latency but leaves HI/LO alone.
                  if (!dz_q) begin
                     hi_q <= tmp_q[63:32];
                     lo_q <= tmp_q[31:0];
                  end
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.Busy   = busy_q;
   assign bus.HI     = hi_q;
   assign bus.LO     = lo_q;
   assign bus.MDUOut = (bus.MDUOp == 4'b0101) ? hi_q :
                       (bus.MDUOp == 4'b0110) ? lo_q : 32'd0;

endmodule
